bcd2bin_seq: RTL and testbench

Sequential BCD-to-binary converter: the inverse of the calculator's binary-to-BCD digit splitter. It captures eight BCD digits (num7 = most significant, num0 = least significant) from keypad/display entry and iterates multiply-by-10-and-add, one digit per clock. It returns the 27-bit binary operand to the ALU. Start/busy/done handshake; flags invalid digits.

---
 rtl/bcd2bin_seq_if.sv | 30 +++
 rtl/bcd2bin_seq.sv | 97 +++++++++
 tb/tb_bcd2bin_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if: handshake and data bundle for the BCD-to-binary converter.
//   master: drives inicio and the eight BCD digits, observes the result.
//   slave : the converter; receives start/digits, returns numero/pronto/
//           ocupado/erro.
//   inicio      start request
//   num0..num7  BCD digits, num0 = units, num7 = 10^7
//   numero      binary result (LARGURA bits), held until next completion
//   pronto      one-cycle completion pulse
//   ocupado     conversion in progress
//   erro        an input digit was > 9; held with numero
interface bcd2bin_seq_if #(
    parameter int LARGURA = 27
);
    logic               inicio;
    logic [3:0]         num0, num1, num2, num3, num4, num5, num6, num7;
    logic [LARGURA-1:0] numero;
    logic               pronto;
    logic               ocupado;
    logic               erro;

    modport master (
        output inicio, num0, num1, num2, num3, num4, num5, num6, num7,
        input  numero, pronto, ocupado, erro
    );

    modport slave (
        input  inicio, num0, num1, num2, num3, num4, num5, num6, num7,
        output numero, pronto, ocupado, erro
    );
endinterface

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter. Latches eight BCD digits
// on a start request and accumulates acc = acc*10 + digit, most significant
// digit first, one digit per clock. The result is presented for one cycle
// with pronto and then held on numero/erro until the next completion.
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    slave side of bcd2bin_seq_if (inicio, num0..num7 in;
//          numero, pronto, ocupado, erro out)
module bcd2bin_seq #(
    parameter int N_DIGITOS = 8,
    parameter int LARGURA   = 27
) (
    input  logic         clk,
    input  logic         rst_n,
    bcd2bin_seq_if.slave bus
);
    localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

    typedef enum logic [1:0] {OCIOSO, CONVERTE, FIM} estado_t;

    estado_t              estado_q;
    logic [4*N_DIGITOS-1:0] dig_q;
    logic [LARGURA-1:0]   acc_q, acc_d;
    logic [IW-1:0]        idx_q;
    logic                 err_q, err_d;
    logic [LARGURA-1:0]   numero_q;
    logic                 pronto_q, ocupado_q, erro_q;
    logic [3:0]           dig_cur;

    // One accumulation step for the digit currently selected by idx_q.
    // acc*10 is built from shifts, kept in LARGURA bits (cannot overflow for
    // a legal LARGURA). An invalid digit contributes 0 and sets the flag.
    always_comb begin
        dig_cur = dig_q[idx_q*4 +: 4];
        err_d   = err_q | (dig_cur > 4'd9);
        acc_d   = (acc_q << 3) + (acc_q << 1)
                + ((dig_cur > 4'd9) ? '0 : {{(LARGURA-4){1'b0}}, dig_cur});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            dig_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            numero_q  <= '0;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    pronto_q <= 1'b0;
                    if (bus.inicio) begin
                        dig_q     <= {bus.num7, bus.num6, bus.num5, bus.num4,
                                      bus.num3, bus.num2, bus.num1, bus.num0};
                        acc_q     <= '0;
                        err_q     <= 1'b0;
                        idx_q     <= IW'(N_DIGITOS - 1);
                        ocupado_q <= 1'b1;
                        estado_q  <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    acc_q <= acc_d;
                    err_q <= err_d;
                    if (idx_q == '0) begin
                        // Last digit: publish straight from the step result so
                        // numero/erro are valid in the same cycle pronto rises.
                        numero_q  <= err_d ? '0 : acc_d;
                        erro_q    <= err_d;
                        pronto_q  <= 1'b1;
                        ocupado_q <= 1'b0;
                        estado_q  <= FIM;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                FIM: begin
                    pronto_q <= 1'b0;
                    estado_q <= OCIOSO;
                end
                default: begin
                    pronto_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.numero  = numero_q;
    assign bus.pronto  = pronto_q;
    assign bus.ocupado = ocupado_q;
    assign bus.erro    = erro_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd2bin_seq_if #(.LARGURA(27)) bus ();

    bcd2bin_seq #(.N_DIGITOS(8), .LARGURA(27)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [26:0] num;
        logic        err;
        int          e0;
        string       nm;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic set_digits(input logic [31:0] d);
        {bus.num7, bus.num6, bus.num5, bus.num4,
         bus.num3, bus.num2, bus.num1, bus.num0} = d;
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int t;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Waits (bounded) for the converter to be idle; called at posedge+#1.
    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.ocupado || bus.pronto) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk("idle_timeout", 32'(n), 32'd0);
    endtask

    // Single-cycle start pulse; pushes the expectation when exp_on is set.
    task automatic start(input logic [31:0] d, input logic exp_on,
                         input logic [26:0] en, input logic ee, input string nm);
        exp_t x;
        wait_idle();
        set_digits(d);
        bus.inicio = 1'b1;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        if (exp_on) begin
            x.num = en; x.err = ee; x.e0 = cyc; x.nm = nm;
            sb.push_back(x);
        end
    endtask

    // Monitor: every pronto pulse is checked against the scoreboard head.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n && bus.pronto) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pronto", 32'd1, 32'd0);
                end else begin
                    x = sb.pop_front();
                    chk({x.nm, "_numero"},  32'(bus.numero), 32'(x.num));
                    chk({x.nm, "_erro"},    32'(bus.erro),   32'(x.err));
                    chk({x.nm, "_latency"}, 32'(cyc - x.e0), 32'd8);
                    chk({x.nm, "_ocupado"}, 32'(bus.ocupado), 32'd0);
                end
            end
        end
    end

    initial begin
        int vals[1000];
        exp_t x;
        int n;

        bus.inicio = 1'b0;
        set_digits(32'h0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_numero",  32'(bus.numero),  32'd0);
        chk("rst_pronto",  32'(bus.pronto),  32'd0);
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_erro",    32'(bus.erro),    32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 12345678, with ocupado high for the 8 conversion cycles
        start(32'h12345678, 1'b1, 27'h0BC614E, 1'b0, "v12345678");
        for (int i = 0; i < 8; i++) begin
            chk("busy_window", 32'(bus.ocupado), 32'd1);
            @(posedge clk); #1;
        end

        start(32'h99999999, 1'b1, 27'h5F5E0FF, 1'b0, "all9");
        start(32'h00000000, 1'b1, 27'd0,       1'b0, "all0");

        // num3 = C -> error, numero forced to 0; next valid conversion clears it
        start(32'h7654C210, 1'b1, 27'd0,  1'b1, "bad_digit");
        start(32'h00000042, 1'b1, 27'd42, 1'b0, "after_err");

        // Inputs changed and inicio re-pulsed mid-conversion: ignored
        start(32'h11111111, 1'b1, 27'd11111111, 1'b0, "retrig");
        repeat (2) @(posedge clk); #1;
        set_digits(32'h22222222);
        bus.inicio = 1'b1;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        repeat (20) @(posedge clk); #1;

        // Reset during conversion discards it
        start(32'h87654321, 1'b0, 27'd0, 1'b0, "aborted");
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("midrst_numero",  32'(bus.numero),  32'd0);
        chk("midrst_pronto",  32'(bus.pronto),  32'd0);
        repeat (12) @(posedge clk); #1;
        start(32'h00000042, 1'b1, 27'd42, 1'b0, "post_rst");

        // Round trip with inicio held high: a new conversion every 10 cycles
        for (int i = 0; i < 1000; i++) vals[i] = int'($urandom_range(0, 99999999));
        wait_idle();
        set_digits(to_bcd(vals[0]));
        bus.inicio = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            x.num = 27'(vals[i]); x.err = 1'b0; x.e0 = cyc; x.nm = "roundtrip";
            sb.push_back(x);
            if (i == 999) begin
                bus.inicio = 1'b0;
            end else begin
                set_digits(to_bcd(vals[i+1]));
                repeat (9) @(posedge clk);
            end
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (5) @(posedge clk); #1;
        chk("drain_left", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
